// File: rtl/star_pkg.sv
// Shared encodings for the star motion sequencer: position sensor codes,
// one-hot motor drive codes and the sequencer state enumeration.
package star_pkg;

   localparam logic [1:0] GRILL_CLOSED  = 2'b00;
   localparam logic [1:0] GRILL_OPEN    = 2'b01;
   localparam logic [1:0] GRILL_INVALID = 2'b11;

   localparam logic [1:0] STAR_UP      = 2'b00;
   localparam logic [1:0] STAR_HIDDEN  = 2'b01;
   localparam logic [1:0] STAR_INVALID = 2'b11;

   localparam logic [3:0] MOTOR_STOP        = 4'b0000;
   localparam logic [3:0] MOTOR_GRILL_OPEN  = 4'b1000;
   localparam logic [3:0] MOTOR_GRILL_CLOSE = 4'b0100;
   localparam logic [3:0] MOTOR_STAR_HIDE   = 4'b0010;
   localparam logic [3:0] MOTOR_STAR_SHOW   = 4'b0001;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_OPEN_GRILL,
      ST_MOVE_STAR,
      ST_CLOSE_GRILL,
      ST_FAULT
   } seq_state_t;

endpackage

// File: rtl/seq_step_timer.sv
// Per-step watchdog counter: cleared on state entry, counts cycles while a
// motion step runs, and flags the cycle in which the step reaches its limit.
module seq_step_timer #(
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int CNT_W          = 16
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] count;

   // Saturating count so a long-held step can never wrap back to a small value.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         count <= '0;
      end else if (i_enable && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

   assign o_expired = i_enable && (count >= LIMIT);

endmodule

// File: rtl/star_motion_sequencer.sv
// Star/grill motion sequencer: open grill, move star, close grill, all one motor at a time.
// Defining STAR_SEQ_WATCHDOG_EN adds a per-step timeout that faults after TIMEOUT_CYCLES.
module star_motion_sequencer
   import star_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int CNT_W          = 16
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_cmd_hide,
   input  logic       i_cmd_show,
   input  logic       i_ack,
   input  logic [1:0] i_grill_pos,
   input  logic [1:0] i_star_pos,
   output logic [3:0] o_motor,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_fault
);

   seq_state_t state, state_next;
   logic [1:0] target, target_next, cmd_target;
   logic [3:0] motor_next;
   logic       busy_next, done_next, fault_next;
   logic       pos_invalid;
   logic       timeout;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (2 ** CNT_W) - 1) begin : g_timeout_range
      $error("TIMEOUT_CYCLES must lie in 1 .. 2**CNT_W-1");
   end

`ifdef STAR_SEQ_WATCHDOG_EN
   seq_step_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .CNT_W         (CNT_W)
   ) u_step_timer (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_clear  (state_next != state),
      .i_enable (state inside {ST_OPEN_GRILL, ST_MOVE_STAR, ST_CLOSE_GRILL}),
      .o_expired(timeout)
   );
`else
   assign timeout = 1'b0;
`endif

   // Fault checks take priority over progress so a bad sensor never advances the sequence.
   always_comb begin
      state_next  = state;
      target_next = target;
      done_next   = 1'b0;
      cmd_target  = i_cmd_hide ? STAR_HIDDEN : STAR_UP;
      pos_invalid = (i_grill_pos == GRILL_INVALID) || (i_star_pos == STAR_INVALID);

      case (state)
         ST_IDLE: begin
            if (i_cmd_hide ^ i_cmd_show) begin
               target_next = cmd_target;
               if ((i_star_pos == cmd_target) && (i_grill_pos == GRILL_CLOSED)) begin
                  done_next = 1'b1;
               end else if (i_grill_pos == GRILL_OPEN) begin
                  state_next = ST_MOVE_STAR;
               end else begin
                  state_next = ST_OPEN_GRILL;
               end
            end
         end
         ST_OPEN_GRILL: begin
            if (pos_invalid || timeout) begin
               state_next = ST_FAULT;
            end else if (i_grill_pos == GRILL_OPEN) begin
               state_next = ST_MOVE_STAR;
            end
         end
         ST_MOVE_STAR: begin
            if (pos_invalid || timeout || (i_grill_pos != GRILL_OPEN)) begin
               state_next = ST_FAULT;
            end else if (i_star_pos == target) begin
               state_next = ST_CLOSE_GRILL;
            end
         end
         ST_CLOSE_GRILL: begin
            if (pos_invalid || timeout) begin
               state_next = ST_FAULT;
            end else if (i_grill_pos == GRILL_CLOSED) begin
               state_next = ST_IDLE;
               done_next  = 1'b1;
            end
         end
         ST_FAULT: begin
            if (i_ack) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase

      // Any state change forces one stopped cycle before the next motor engages.
      motor_next = MOTOR_STOP;
      if (state_next == state) begin
         case (state)
            ST_OPEN_GRILL:  motor_next = MOTOR_GRILL_OPEN;
            ST_MOVE_STAR:   motor_next = (target == STAR_HIDDEN) ? MOTOR_STAR_HIDE : MOTOR_STAR_SHOW;
            ST_CLOSE_GRILL: motor_next = MOTOR_GRILL_CLOSE;
            default:        motor_next = MOTOR_STOP;
         endcase
      end

      busy_next  = state_next inside {ST_OPEN_GRILL, ST_MOVE_STAR, ST_CLOSE_GRILL};
      fault_next = (state_next == ST_FAULT);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state   <= ST_IDLE;
         target  <= STAR_UP;
         o_motor <= MOTOR_STOP;
         o_busy  <= 1'b0;
         o_done  <= 1'b0;
         o_fault <= 1'b0;
      end else begin
         state   <= state_next;
         target  <= target_next;
         o_motor <= motor_next;
         o_busy  <= busy_next;
         o_done  <= done_next;
         o_fault <= fault_next;
      end
   end

endmodule

// File: tb/tb_star_motion_sequencer.sv
// Self-checking bench for star_motion_sequencer: a grill/star plant with random travel
// times reacts to o_motor, and each command is compared against a phase-list model.
module tb_star_motion_sequencer;

   localparam int TIMEOUT = 8;

   logic       i_clk = 1'b0;
   logic       i_rst;
   logic       i_cmd_hide;
   logic       i_cmd_show;
   logic       i_ack;
   logic [1:0] i_grill_pos;
   logic [1:0] i_star_pos;
   logic [3:0] o_motor;
   logic       o_busy;
   logic       o_done;
   logic       o_fault;

   int n_checks = 0;
   int n_fail   = 0;

   int         grill_t, star_t, travel;
   logic [3:0] plant_last, prev_motor;
   bit         grill_stuck, star_force_bad, recording;
   int         onehot_bad, gap_bad;
   logic [3:0] obs_q[$];

   star_motion_sequencer #(
      .TIMEOUT_CYCLES(TIMEOUT),
      .CNT_W         (16)
   ) dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_cmd_hide (i_cmd_hide),
      .i_cmd_show (i_cmd_show),
      .i_ack      (i_ack),
      .i_grill_pos(i_grill_pos),
      .i_star_pos (i_star_pos),
      .o_motor    (o_motor),
      .o_busy     (o_busy),
      .o_done     (o_done),
      .o_fault    (o_fault)
   );

   always #5 i_clk = ~i_clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [31:0] packTrace(input logic [3:0] q[$]);
      logic [31:0] v;
      v = '0;
      foreach (q[i]) v = {v[27:0], q[i]};
      return v;
   endfunction

   // One clock: sample just after the edge, log motor activity, then let the plant move.
   task automatic tick();
      @(posedge i_clk);
      #1;
      if ($countones(o_motor) > 1) onehot_bad++;
      if (prev_motor != 4'b0000 && o_motor != 4'b0000 && o_motor != prev_motor) gap_bad++;
      prev_motor = o_motor;
      if (recording && (o_motor !== obs_q[$])) obs_q.push_back(o_motor);
      if (o_motor != plant_last) travel = 0;
      plant_last = o_motor;
      case (o_motor)
         4'b1000: if (!grill_stuck && i_grill_pos != 2'b01) begin
            travel++;
            i_grill_pos = (travel >= grill_t) ? 2'b01 : 2'b10;
         end
         4'b0100: if (!grill_stuck && i_grill_pos != 2'b00) begin
            travel++;
            i_grill_pos = (travel >= grill_t) ? 2'b00 : 2'b10;
         end
         4'b0010: if (i_star_pos != 2'b01) begin
            travel++;
            i_star_pos = (travel >= star_t) ? 2'b01 : 2'b10;
         end
         4'b0001: if (i_star_pos != 2'b00) begin
            travel++;
            i_star_pos = (travel >= star_t) ? 2'b00 : 2'b10;
         end
         default: ;
      endcase
      if (star_force_bad) i_star_pos = 2'b11;
   endtask

   // Issue one command and compare the run against the phases the rules predict.
   task automatic applyStimulus(input string tag, input logic hide, input logic show, input bit inject_show);
      logic [3:0] exp_q[$];
      logic [1:0] target;
      bit         expect_seq, injected;
      int         done_cnt, busy_bad, first_done;
      target     = hide ? 2'b01 : 2'b00;
      expect_seq = (hide ^ show) && !((i_star_pos == target) && (i_grill_pos == 2'b00));
      exp_q.push_back(4'b0000);
      if (expect_seq) begin
         if (i_grill_pos != 2'b01) begin
            exp_q.push_back(4'b1000);
            exp_q.push_back(4'b0000);
         end
         if (i_star_pos != target) begin
            exp_q.push_back(hide ? 4'b0010 : 4'b0001);
            exp_q.push_back(4'b0000);
         end
         exp_q.push_back(4'b0100);
         exp_q.push_back(4'b0000);
      end
      obs_q.delete();
      obs_q.push_back(o_motor);
      recording  = 1'b1;
      done_cnt   = 0;
      busy_bad   = 0;
      first_done = 0;
      injected   = 1'b0;
      i_cmd_hide = hide;
      i_cmd_show = show;
      for (int n = 1; n <= 200; n++) begin
         tick();
         i_cmd_hide = 1'b0;
         i_cmd_show = 1'b0;
         if (o_done === 1'b1) begin
            done_cnt++;
            if (first_done == 0) first_done = n;
         end
         if (o_busy !== (expect_seq && first_done == 0)) busy_bad++;
         if (inject_show && !injected && o_motor == 4'b0010) begin
            i_cmd_show = 1'b1;
            injected   = 1'b1;
         end
         if (first_done != 0 && n >= first_done + 3) break;
         if (!expect_seq && first_done == 0 && n >= 6) break;
      end
      recording = 1'b0;
      checkOutput({tag, ".trace_len"}, 32'(obs_q.size()), 32'(exp_q.size()));
      checkOutput({tag, ".trace"}, packTrace(obs_q), packTrace(exp_q));
      checkOutput({tag, ".done_pulses"}, 32'(done_cnt), (hide ^ show) ? 32'd1 : 32'd0);
      checkOutput({tag, ".busy"}, 32'(busy_bad), 32'd0);
      checkOutput({tag, ".fault"}, 32'(o_fault), 32'd0);
      checkOutput({tag, ".onehot"}, 32'(onehot_bad), 32'd0);
      checkOutput({tag, ".stop_gap"}, 32'(gap_bad), 32'd0);
      if ((hide ^ show) && !expect_seq) checkOutput({tag, ".skip_latency"}, 32'(first_done), 32'd1);
      if (inject_show) checkOutput({tag, ".injected"}, 32'(injected), 32'd1);
   endtask

   task automatic waitForMotor(input string tag, input logic [3:0] code);
      bit found;
      found = 1'b0;
      for (int n = 0; n < 100; n++) begin
         if (o_motor == code) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      checkOutput(tag, 32'(found), 32'd1);
   endtask

   initial begin
      logic h, s;
      int   pick, k;
      i_rst = 1'b1; i_cmd_hide = 1'b0; i_cmd_show = 1'b0; i_ack = 1'b0;
      i_grill_pos = 2'b00; i_star_pos = 2'b00;
      grill_t = 5; star_t = 5; travel = 0;
      plant_last = 4'b0000; prev_motor = 4'b0000;
      grill_stuck = 1'b0; star_force_bad = 1'b0; recording = 1'b0;
      onehot_bad = 0; gap_bad = 0;

      repeat (3) tick();
      checkOutput("reset.motor", 32'(o_motor), 32'd0);
      checkOutput("reset.busy", 32'(o_busy), 32'd0);
      checkOutput("reset.done", 32'(o_done), 32'd0);
      checkOutput("reset.fault", 32'(o_fault), 32'd0);
      i_rst = 1'b0;

      applyStimulus("hide_full", 1'b1, 1'b0, 1'b0);
      applyStimulus("hide_skip", 1'b1, 1'b0, 1'b0);
      applyStimulus("both_cmds", 1'b1, 1'b1, 1'b0);
      applyStimulus("show_full", 1'b0, 1'b1, 1'b0);
      applyStimulus("hide_with_show_in_move", 1'b1, 1'b0, 1'b1);

      for (int r = 0; r < 10; r++) begin
         grill_t = $urandom_range(1, 6);
         star_t  = $urandom_range(1, 6);
         if ($urandom_range(0, 3) == 0) i_grill_pos = 2'b01;
         pick = $urandom_range(0, 4);
         h = (pick == 0) || (pick == 1) || (pick == 2);
         s = (pick == 0) || (pick == 3) || (pick == 4);
         applyStimulus($sformatf("rand%0d", r), h, s, 1'b0);
      end

      grill_t = 2; star_t = 5;
      i_grill_pos = 2'b00; i_star_pos = 2'b00;
      i_cmd_hide = 1'b1;
      tick();
      i_cmd_hide = 1'b0;
      waitForMotor("rst_mid.reach_move", 4'b0010);
      i_rst = 1'b1;
      tick();
      checkOutput("rst_mid.motor", 32'(o_motor), 32'd0);
      checkOutput("rst_mid.busy", 32'(o_busy), 32'd0);
      checkOutput("rst_mid.done", 32'(o_done), 32'd0);
      checkOutput("rst_mid.fault", 32'(o_fault), 32'd0);
      i_rst = 1'b0;
      applyStimulus("after_reset_show", 1'b0, 1'b1, 1'b0);

      i_cmd_hide = 1'b1;
      tick();
      i_cmd_hide = 1'b0;
      waitForMotor("bad_star.reach_move", 4'b0010);
      star_force_bad = 1'b1;
      i_star_pos = 2'b11;
      tick();
      checkOutput("bad_star.fault", 32'(o_fault), 32'd1);
      checkOutput("bad_star.motor", 32'(o_motor), 32'd0);
      checkOutput("bad_star.busy", 32'(o_busy), 32'd0);
      i_cmd_show = 1'b1;
      tick();
      i_cmd_show = 1'b0;
      tick();
      checkOutput("fault_cmd.fault", 32'(o_fault), 32'd1);
      checkOutput("fault_cmd.busy", 32'(o_busy), 32'd0);
      checkOutput("fault_cmd.motor", 32'(o_motor), 32'd0);
      star_force_bad = 1'b0;
      i_star_pos = 2'b10;
      i_ack = 1'b1;
      tick();
      i_ack = 1'b0;
      checkOutput("ack.fault", 32'(o_fault), 32'd0);
      checkOutput("ack.busy", 32'(o_busy), 32'd0);
      applyStimulus("recover_show", 1'b0, 1'b1, 1'b0);

      grill_stuck = 1'b1;
      i_cmd_hide = 1'b1;
      tick();
      i_cmd_hide = 1'b0;
`ifdef STAR_SEQ_WATCHDOG_EN
      k = 0;
      while (o_fault !== 1'b1 && k < 50) begin
         tick();
         k++;
      end
      checkOutput("timeout.cycles", 32'(k), 32'(TIMEOUT));
      checkOutput("timeout.motor", 32'(o_motor), 32'd0);
      checkOutput("timeout.busy", 32'(o_busy), 32'd0);
      i_ack = 1'b1;
      tick();
      i_ack = 1'b0;
      checkOutput("timeout_ack.fault", 32'(o_fault), 32'd0);
`else
      k = 0;
      repeat (5 * TIMEOUT) begin
         tick();
         if (o_fault === 1'b1) k++;
      end
      checkOutput("no_watchdog.fault_cycles", 32'(k), 32'd0);
      checkOutput("no_watchdog.motor", 32'(o_motor), 32'h8);
      checkOutput("no_watchdog.busy", 32'(o_busy), 32'd1);
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      checkOutput("no_watchdog_rst.busy", 32'(o_busy), 32'd0);
      checkOutput("no_watchdog_rst.motor", 32'(o_motor), 32'd0);
`endif
      grill_stuck = 1'b0;
      checkOutput("final.onehot", 32'(onehot_bad), 32'd0);
      checkOutput("final.stop_gap", 32'(gap_bad), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
